// File: rtl/izzy_cmd_if.sv
// Command byte stream into the izzy command sequencer.
interface izzy_cmd_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/izzy_cmd_seq.sv
// Command sequencer feeding slash: PARADISE pulses, CITY/welcome levels, LOCOMOTION request/ack.
// Optional 2-entry input command FIFO enabled by defining IZZY_CMD_FIFO_EN.
module izzy_cmd_seq #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic             clk,
    input  logic             resetb,
    izzy_cmd_if.slave        cmd,
    input  logic             jungle,
    output logic             paradise,
    output logic             city,
    output logic             locomotion,
    output logic [1:0]       welcome,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    localparam logic [1:0] OP_NOP      = 2'b00;
    localparam logic [1:0] OP_PARADISE = 2'b01;
    localparam logic [1:0] OP_CITY     = 2'b10;
    localparam logic [1:0] OP_LOCO     = 2'b11;

    localparam logic [TIMEOUT_W-1:0] TCNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_e                 state_q,    state_d;
    logic [3:0]             cnt_q,      cnt_d;
    logic [TIMEOUT_W-1:0]   tcnt_q,     tcnt_d;
    logic                   paradise_q, paradise_d;
    logic                   city_q,     city_d;
    logic                   loco_q,     loco_d;
    logic [1:0]             welcome_q,  welcome_d;
    logic                   busy_q,     busy_d;
    logic                   terr_q,     terr_d;
    logic                   ready_q,    ready_d;

    logic                   take_s;
    logic [7:0]             byte_s;

`ifdef IZZY_CMD_FIFO_EN
    logic [1:0][7:0]        fifo_q,     fifo_d;
    logic                   rd_ptr_q,   rd_ptr_d;
    logic                   wr_ptr_q,   wr_ptr_d;
    logic [1:0]             count_q,    count_d;
    logic                   push_s;

    // ready_q mirrors !full, so a full FIFO never takes a push even when it pops the same cycle
    assign push_s = cmd.cmd_valid & ready_q;
    assign take_s = (state_q == ST_IDLE) && (count_q != 2'd0);
    assign byte_s = fifo_q[rd_ptr_q];

    // FIFO storage, pointers and occupancy next-state
    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + {1'b0, push_s} - {1'b0, take_s};
        if (push_s) begin
            fifo_d[wr_ptr_q] = cmd.cmd_data;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (take_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end
`else
    assign take_s = cmd.cmd_valid & ready_q;
    assign byte_s = cmd.cmd_data;
`endif

    // FSM and output next-state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        paradise_d = paradise_q;
        city_d     = city_q;
        loco_d     = loco_q;
        welcome_d  = welcome_q;
        terr_d     = terr_q;

        case (state_q)
            ST_IDLE: begin
                if (take_s) begin
                    welcome_d = byte_s[5:4];
                    case (byte_s[7:6])
                        OP_NOP: begin
                            if (byte_s[0]) begin
                                terr_d = 1'b0;
                            end else begin
                                terr_d = terr_q;
                            end
                        end
                        OP_PARADISE: begin
                            state_d    = ST_DRIVE;
                            paradise_d = 1'b1;
                            cnt_d      = byte_s[3:0];
                        end
                        OP_CITY: begin
                            city_d = byte_s[0];
                        end
                        OP_LOCO: begin
                            state_d = ST_WAIT_ACK;
                            loco_d  = 1'b1;
                            tcnt_d  = '0;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_IDLE;
                    paradise_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WAIT_ACK: begin
                // ack is checked first so a same-cycle ack beats the timeout
                if (jungle) begin
                    state_d = ST_IDLE;
                    loco_d  = 1'b0;
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d = ST_IDLE;
                    loco_d  = 1'b0;
                    terr_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d    = ST_IDLE;
                paradise_d = 1'b0;
                loco_d     = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
`ifdef IZZY_CMD_FIFO_EN
        ready_d = (count_d != 2'd2);
`else
        ready_d = (state_d == ST_IDLE);
`endif
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            tcnt_q     <= '0;
            paradise_q <= 1'b0;
            city_q     <= 1'b0;
            loco_q     <= 1'b0;
            welcome_q  <= 2'd0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            ready_q    <= 1'b0;
`ifdef IZZY_CMD_FIFO_EN
            fifo_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            paradise_q <= paradise_d;
            city_q     <= city_d;
            loco_q     <= loco_d;
            welcome_q  <= welcome_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
            ready_q    <= ready_d;
`ifdef IZZY_CMD_FIFO_EN
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
`endif
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign paradise      = paradise_q;
    assign city          = city_q;
    assign locomotion    = loco_q;
    assign welcome       = welcome_q;
    assign busy          = busy_q;
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_izzy_cmd_seq.sv
// Directed bench for izzy_cmd_seq; outputs are sampled 1ns after each rising edge.
module tb_izzy_cmd_seq;

    localparam int TIMEOUT = 200;
`ifdef IZZY_CMD_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       resetb = 1'b0;
    logic       jungle = 1'b0;
    logic       paradise, city, locomotion, busy, timeout_err;
    logic [1:0] welcome;
    int         n_tests = 0;
    int         n_fail  = 0;

    izzy_cmd_if u_if ();

    izzy_cmd_seq #(
        .TIMEOUT_W (8),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .cmd         (u_if.slave),
        .jungle      (jungle),
        .paradise    (paradise),
        .city        (city),
        .locomotion  (locomotion),
        .welcome     (welcome),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // With the FIFO the command is popped one edge after the push, so add that edge here
    task automatic accept(input logic [7:0] d);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_data  = d;
        step();
        u_if.cmd_valid = 1'b0;
`ifdef IZZY_CMD_FIFO_EN
        step();
`endif
    endtask

    initial begin
        int w;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_data  = 8'h00;

        // 1: reset
        step();
        step();
        chk("rst_paradise", paradise, 8'd0);
        chk("rst_city", city, 8'd0);
        chk("rst_loco", locomotion, 8'd0);
        chk("rst_welcome", welcome, 8'd0);
        chk("rst_busy", busy, 8'd0);
        chk("rst_terr", timeout_err, 8'd0);
        chk("rst_ready", u_if.cmd_ready, 8'd0);
        resetb = 1'b1;
        #1;
        chk("rel_ready_pre_edge", u_if.cmd_ready, 8'd0);
        step();
        chk("rel_ready", u_if.cmd_ready, 8'd1);
        chk("rel_busy", busy, 8'd0);

        // 2: PARADISE N=3, welcome=2
        accept(8'h63);
        for (int k = 1; k <= 5; k++) begin
            chk("t2_welcome", welcome, 8'd2);
            chk("t2_paradise", paradise, {7'd0, k <= 4});
            chk("t2_busy", busy, {7'd0, k <= 4});
            chk("t2_ready", u_if.cmd_ready, {7'd0, FIFO | (k == 5)});
            if (k < 5) step();
        end

        // 3: CITY back-to-back
        u_if.cmd_valid = 1'b1;
        u_if.cmd_data  = 8'h81;
        step();
`ifndef IZZY_CMD_FIFO_EN
        chk("t3_city1", city, 8'd1);
        chk("t3_ready1", u_if.cmd_ready, 8'd1);
        chk("t3_welcome", welcome, 8'd0);
`endif
        u_if.cmd_data = 8'h80;
        step();
        u_if.cmd_valid = 1'b0;
`ifdef IZZY_CMD_FIFO_EN
        chk("t3_city1", city, 8'd1);
        chk("t3_ready1", u_if.cmd_ready, 8'd1);
        step();
`endif
        chk("t3_city0", city, 8'd0);
        chk("t3_ready2", u_if.cmd_ready, 8'd1);

        accept(8'h91);
        chk("city_set", city, 8'd1);
        chk("welcome_1", welcome, 8'd1);
        jungle = 1'b1;
        step();
        jungle = 1'b0;
        chk("jungle_idle_busy", busy, 8'd0);
        chk("jungle_idle_loco", locomotion, 8'd0);

        // 4: LOCOMOTION acked on its 6th cycle
        accept(8'hC0);
        for (int k = 1; k <= 6; k++) begin
            chk("t4_loco", locomotion, 8'd1);
            chk("t4_busy", busy, 8'd1);
            chk("t4_city_hold", city, 8'd1);
            if (k == 6) jungle = 1'b1;
            step();
        end
        jungle = 1'b0;
        chk("t4_loco_drop", locomotion, 8'd0);
        chk("t4_busy_drop", busy, 8'd0);
        chk("t4_terr", timeout_err, 8'd0);
        chk("t4_ready", u_if.cmd_ready, 8'd1);

        // 5: timeout, then sticky error and its clearing
        accept(8'hC0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            chk("t5_loco_held", locomotion, 8'd1);
            chk("t5_terr_low", timeout_err, 8'd0);
            step();
        end
        chk("t5_loco_drop", locomotion, 8'd0);
        chk("t5_terr_set", timeout_err, 8'd1);
        chk("t5_busy", busy, 8'd0);
        accept(8'h30);
        chk("t5_nop_keep", timeout_err, 8'd1);
        chk("t5_welcome3", welcome, 8'd3);
        accept(8'h01);
        chk("t5_nop_clear", timeout_err, 8'd0);
        chk("t5_welcome0", welcome, 8'd0);

        accept(8'hC0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == TIMEOUT) jungle = 1'b1;
            step();
        end
        jungle = 1'b0;
        chk("ack_vs_to_loco", locomotion, 8'd0);
        chk("ack_vs_to_terr", timeout_err, 8'd0);

        accept(8'hF0);
        chk("first_ack_loco", locomotion, 8'd1);
        chk("first_ack_welcome", welcome, 8'd3);
        jungle = 1'b1;
        step();
        jungle = 1'b0;
        chk("first_ack_drop", locomotion, 8'd0);
        chk("first_ack_busy", busy, 8'd0);

        // 6: reset in the middle of a long PARADISE
        accept(8'h4F);
        step();
        step();
        chk("t6_paradise_on", paradise, 8'd1);
        resetb = 1'b0;
        #1;
        chk("t6_paradise_off", paradise, 8'd0);
        chk("t6_busy", busy, 8'd0);
        chk("t6_ready", u_if.cmd_ready, 8'd0);
        chk("t6_city", city, 8'd0);
        chk("t6_welcome", welcome, 8'd0);
        step();
        resetb = 1'b1;
        step();
        chk("t6_ready_back", u_if.cmd_ready, 8'd1);
        chk("t6_paradise_quiet", paradise, 8'd0);

`ifdef IZZY_CMD_FIFO_EN
        // FIFO fills while the FSM is busy; the third command stalls until a pop
        accept(8'h4F);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_data  = 8'h81;
        step();
        u_if.cmd_data = 8'h80;
        step();
        chk("fifo_full_ready", u_if.cmd_ready, 8'd0);
        u_if.cmd_data = 8'hB1;
        w = 0;
        while (!u_if.cmd_ready && w < 40) begin
            step();
            w++;
        end
        chk("fifo_stall_bounded", {7'd0, w < 40}, 8'd1);
        chk("fifo_stalled", {7'd0, w > 0}, 8'd1);
        step();
        u_if.cmd_valid = 1'b0;
        repeat (6) step();
        chk("fifo_city", city, 8'd1);
        chk("fifo_welcome", welcome, 8'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
